// File: rtl/apb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_if
//
// Groups the APB3 handshake and data signals between the bridge (master) and
// the memory completer (slave).
//
// Parameters:
//   AW - address width
//   DW - data width
//
// Signals:
//   psel, penable, pwrite, paddr, pwdata : driven by the master
//   pready, prdata, pslverr              : driven by the slave
// ---------------------------------------------------------------------------
interface apb_mem_slave_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//
// APB3 completer backed by a DEPTH-word register-file memory. A transfer is
// a registered SETUP cycle followed by one or more ACCESS cycles; pready
// is decoded purely from flops so there is no input-to-pready path.
//
// Optional feature: define APB_SLV_WAIT_EN to enable a 4-bit wait-state
// counter that stretches ACCESS to WAIT_CYCLES+1 cycles. Without the macro
// the counter is compiled out and every ACCESS completes in one cycle.
//
// Ports:
//   pclk    - APB clock, rising-edge active
//   presetn - asynchronous active-low reset (also clears the memory)
//   bus     - apb_mem_slave_if slave modport (psel/penable/pwrite/paddr/
//             pwdata in, pready/prdata/pslverr out)
// ---------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic           pclk,
    input  logic           presetn,
    apb_mem_slave_if.slave bus
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]    st_q, st_d;
    logic [IW-1:0] a_q, a_d;
    logic          w_q, w_d;
    logic          err_q, err_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] prdata_q, prdata_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic pready;
    logic start;
    logic latch;

    // A new transfer is offered when the bridge is in its setup phase.
    assign start = bus.psel & ~bus.penable;

`ifdef APB_SLV_WAIT_EN
    logic [3:0] wcnt_q, wcnt_d;

    assign pready = (st_q == ST_ACCESS) && (wcnt_q == 4'd0);

    // Wait counter is armed while in SETUP so it is valid on the first
    // ACCESS cycle, then counts down to the completion cycle.
    always_comb begin
        wcnt_d = wcnt_q;
        if (st_q == ST_SETUP) begin
            wcnt_d = 4'(WAIT_CYCLES);
        end else if ((st_q == ST_ACCESS) && (wcnt_q != 4'd0)) begin
            wcnt_d = wcnt_q - 4'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wcnt_q <= 4'd0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    assign pready = (st_q == ST_ACCESS);
`endif

    // Transfer FSM, request capture, read-data load and memory commit.
    // Out-of-range requests are flagged at capture time so the full paddr
    // never needs to be kept; only the in-range index is stored.
    always_comb begin
        st_d     = st_q;
        a_d      = a_q;
        w_d      = w_q;
        d_d      = d_q;
        err_d    = err_q;
        prdata_d = prdata_q;
        mem_d    = mem_q;
        latch    = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    st_d  = ST_SETUP;
                    latch = 1'b1;
                end
            end
            ST_SETUP: begin
                st_d = ST_ACCESS;
                if (!w_q) begin
                    prdata_d = err_q ? '0 : mem_q[a_q];
                end
            end
            ST_ACCESS: begin
                if (!bus.psel) begin
                    st_d = ST_IDLE;
                end else if (pready) begin
                    if (w_q && !err_q) begin
                        mem_d[a_q] = d_q;
                    end
                    if (start) begin
                        st_d  = ST_SETUP;
                        latch = 1'b1;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase

        if (latch) begin
            a_d   = IW'(bus.paddr);
            w_d   = bus.pwrite;
            d_d   = bus.pwdata;
            err_d = ({1'b0, bus.paddr} >= DEPTH_LIM);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            st_q     <= ST_IDLE;
            a_q      <= '0;
            w_q      <= 1'b0;
            d_q      <= '0;
            err_q    <= 1'b0;
            prdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            st_q     <= st_d;
            a_q      <= a_d;
            w_q      <= w_d;
            d_q      <= d_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.pready  = pready;
    assign bus.prdata  = prdata_q;
    assign bus.pslverr = pready & err_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_slave
//
// Directed bench for apb_mem_slave. A transaction-level model (memory array
// plus per-transfer timing arithmetic) sets the expected pready/pslverr/
// prdata for every cycle; a negedge process compares them against the DUT.
// Literal checks after key transfers pin the model to hand-computed values.
// Honours APB_SLV_WAIT_EN: wait-state and abort scenarios use WAIT_CYCLES=3.
// ---------------------------------------------------------------------------
module tb_apb_mem_slave;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
`ifdef APB_SLV_WAIT_EN
    localparam int WAIT = 3;
`else
    localparam int WAIT = 0;
`endif

    logic pclk    = 1'b0;
    logic presetn = 1'b0;

    int checks = 0;
    int errors = 0;

    apb_mem_slave_if #(.AW(AW), .DW(DW)) bus ();

    apb_mem_slave #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(3)
    ) dut (
        .pclk(pclk),
        .presetn(presetn),
        .bus(bus)
    );

    always #5 pclk = ~pclk;

    // Model state: memory contents and the outputs expected this cycle.
    logic [DW-1:0] model_mem [DEPTH];
    logic          exp_pready  = 1'b0;
    logic          exp_pslverr = 1'b0;
    logic          exp_rd      = 1'b0;
    logic [DW-1:0] exp_prdata  = '0;
    bit            chk_en      = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int addr);
        return (addr < DEPTH) ? model_mem[6'(addr)] : 8'h00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge pclk) begin
        if (chk_en) begin
            checkOutput("pready", 32'(bus.pready), 32'(exp_pready));
            checkOutput("pslverr", 32'(bus.pslverr), 32'(exp_pslverr));
            if (exp_rd) checkOutput("prdata", 32'(bus.prdata), 32'(exp_prdata));
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
            exp_pready  = 1'b0;
            exp_pslverr = 1'b0;
            exp_rd      = 1'b0;
        end
    endtask

    // Issues one transfer starting in the current cycle. Returns at the
    // completion cycle with psel/penable still high; with b2b the caller
    // immediately presents the next setup in that same cycle.
    task automatic applyStimulus(input bit wr, input int addr,
                                 input logic [DW-1:0] data, input bit abort);
        bit err;
        err = (addr >= DEPTH);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = 8'(addr);
        bus.pwdata  = data;
        tick();
        // DUT SETUP cycle: scramble address/data to prove they were latched
        bus.penable = 1'b1;
        bus.paddr   = ~8'(addr);
        bus.pwdata  = ~data;
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        exp_rd      = 1'b0;
        for (int k = 0; k <= WAIT; k++) begin
            tick();
            if (abort) begin
                bus.psel    = 1'b0;
                bus.penable = 1'b0;
                exp_pready  = 1'b0;
                exp_pslverr = 1'b0;
                exp_rd      = 1'b0;
                return;
            end
            exp_pready  = (k == WAIT);
            exp_pslverr = (k == WAIT) && err;
            exp_rd      = (k == WAIT) && !wr;
            if (k == WAIT) begin
                if (!wr) exp_prdata = model_read(addr);
                if (wr && !err) model_mem[6'(addr)] = data;
            end
        end
    endtask

    initial begin
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        model_clear();

        repeat (2) @(posedge pclk);
        #1;
        checkOutput("rst_pready", 32'(bus.pready), 32'h0);
        checkOutput("rst_prdata", 32'(bus.prdata), 32'h0);
        checkOutput("rst_pslverr", 32'(bus.pslverr), 32'h0);
        presetn = 1'b1;
        chk_en  = 1'b1;
        idle(1);

        $display("[TB] zero-wait / wait-state write then read");
        applyStimulus(1'b1, 'h10, 8'hA5, 1'b0);
        checkOutput("wr10_pready_lit", 32'(bus.pready), 32'h1);
        idle(1);
        applyStimulus(1'b0, 'h10, 8'h00, 1'b0);
        checkOutput("rd10_lit", 32'(bus.prdata), 32'hA5);
        checkOutput("rd10_err_lit", 32'(bus.pslverr), 32'h0);
        idle(1);
        applyStimulus(1'b1, 'h3F, 8'h5C, 1'b0);
        idle(1);
        applyStimulus(1'b0, 'h3F, 8'h00, 1'b0);
        checkOutput("rd3f_lit", 32'(bus.prdata), 32'h5C);
        idle(1);

        $display("[TB] out-of-range access");
        applyStimulus(1'b1, 'h40, 8'hFF, 1'b0);
        checkOutput("wr40_err_lit", 32'(bus.pslverr), 32'h1);
        idle(1);
        applyStimulus(1'b0, 'h40, 8'h00, 1'b0);
        checkOutput("rd40_err_lit", 32'(bus.pslverr), 32'h1);
        checkOutput("rd40_data_lit", 32'(bus.prdata), 32'h0);
        idle(1);
        applyStimulus(1'b0, 'h00, 8'h00, 1'b0);
        checkOutput("rd00_alias_lit", 32'(bus.prdata), 32'h0);
        idle(1);

`ifdef APB_SLV_WAIT_EN
        $display("[TB] abort during access");
        applyStimulus(1'b1, 'h05, 8'h11, 1'b1);
        idle(2);
        applyStimulus(1'b0, 'h05, 8'h00, 1'b0);
        checkOutput("rd05_abort_lit", 32'(bus.prdata), 32'h0);
        idle(1);
`endif

        $display("[TB] reset mid-access");
        applyStimulus(1'b1, 'h01, 8'h77, 1'b0);
        idle(1);
        applyStimulus(1'b0, 'h01, 8'h00, 1'b0);
        checkOutput("rd01_pre_lit", 32'(bus.prdata), 32'h77);
        idle(1);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 8'h01;
        bus.pwdata  = 8'h22;
        tick();
        bus.penable = 1'b1;
        tick();
        exp_pready = (WAIT == 0);
        #2;
        presetn     = 1'b0;
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        exp_rd      = 1'b0;
        model_clear();
        #1;
        checkOutput("midrst_pready", 32'(bus.pready), 32'h0);
        checkOutput("midrst_prdata", 32'(bus.prdata), 32'h0);
        checkOutput("midrst_pslverr", 32'(bus.pslverr), 32'h0);
        tick();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        #2;
        presetn = 1'b1;
        idle(1);
        applyStimulus(1'b0, 'h01, 8'h00, 1'b0);
        checkOutput("rd01_post_lit", 32'(bus.prdata), 32'h0);
        idle(1);

        $display("[TB] back-to-back transfers");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, i, 8'(i + 1), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, i, 8'h00, 1'b0);
            checkOutput("b2b_rd_lit", 32'(bus.prdata), 32'(i + 1));
        end
        idle(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
